mem_fill_sequencer: RTL and testbench
=====================================

MEM_FILL_SEQUENCER -- requirements
Module: mem_fill_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 8, bytes per cache block; only 8 is supported.
REQ-002 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, cache controller requests a block transfer.
REQ-006 SHALL have port req_ready, output, 1, sequencer idle and able to accept a request.
REQ-007 SHALL have port req_writeback, input, 1, victim block is dirty and needs write-back first.
REQ-008 SHALL have port wb_addr, input, 32, any byte address inside the victim block.
REQ-009 SHALL have port wb_line, input, 64, victim block data; byte i is at bits 8i+7:8i.
REQ-010 SHALL have port fill_addr, input, 32, any byte address inside the block to fetch.
REQ-011 SHALL have port fill_line, output, 64, fetched block data, same byte order as wb_line.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the transfer is complete.
REQ-013 SHALL have port mem_addr, output, 32, byte address to main memory.
REQ-014 SHALL have port mem_wdata, output, 8, write byte to main memory.
REQ-015 SHALL have port mem_we, output, 1, main memory write strobe.
REQ-016 SHALL have port mem_rdata, input, 8, main memory read byte, combinational from mem_addr.
REQ-017 SHALL have ports req_cnt and wb_cnt, output, CNT_W each, accepted-request and write-back statistics.

Function
REQ-018 SHALL implement the states IDLE, WB, FILL and DONE with a 3-bit byte counter idx.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-020 On accept, the block SHALL capture wb_base = {wb_addr[31:3], 3'b000}, fill_base = {fill_addr[31:3], 3'b000} and wb_line, set idx = 0, and go to WB if req_writeback is 1, else FILL.
REQ-021 In WB, outputs SHALL be mem_we = 1, mem_addr = {wb_base[31:3], idx} and mem_wdata = captured byte idx.
REQ-022 In WB, idx SHALL increment each cycle; when idx = 7, idx wraps to 0 and the state goes to FILL.
REQ-023 In FILL, outputs SHALL be mem_we = 0 and mem_addr = {fill_base[31:3], idx}.
REQ-024 In FILL, mem_rdata SHALL be written into fill_line byte idx at each edge; after idx = 7 the state goes to DONE.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, then the state returns to IDLE.
REQ-026 fill_line SHALL hold its value from DONE until the next FILL overwrites it.
REQ-027 Latency SHALL be fixed, counting the accept edge as cycle 0: no write-back gives done high in cycle 9; write-back gives done high in cycle 17.
REQ-028 The address low 3 bits SHALL be replaced by idx with no carry into bit 3, so 0xFFFFFFF8..0xFFFFFFFF do not wrap.
REQ-029 Inputs SHALL be ignored outside IDLE; captured values SHALL NOT change mid-transfer.
REQ-030 If wb_base equals fill_base, both phases SHALL still run, WB before FILL.
REQ-031 req_cnt SHALL increment per accept and wb_cnt per accept with req_writeback = 1; both saturate at all-ones.
REQ-032 mem_we, done and req_ready SHALL be decoded from the state register only, giving glitch-free strobes.

Reset
REQ-033 On rst sampled high, the block SHALL take state IDLE, idx 0, fill_line 0, req_cnt 0 and wb_cnt 0, so the outputs are req_ready 1, done 0, mem_we 0, mem_addr 0 and mem_wdata 0.
REQ-034 rst during WB or FILL SHALL abort the transfer: no further mem_we after the reset edge, no done pulse, and a partially filled fill_line is cleared.
REQ-035 rst SHALL have priority over a simultaneous req_valid.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE = 0, WB = 1, FILL = 2, DONE = 3), BLOCK_BYTES and OFFSET_W = 3.
REQ-037 The saturating statistics counter SHALL be one sub-module, sat_counter (width parameter, inc input, synchronous reset), instantiated twice.

Verification
REQ-038 Clean fill: fill_addr 0x00000105, memory bytes 0x100..0x107 = 0x10..0x17, req_writeback 0 -> mem_addr 0x100..0x107 in cycles 1-8, done in cycle 9, fill_line 0x1716151413121110.
REQ-039 Dirty fill: wb_addr 0x00000208, wb_line 0x8877665544332211, fill_addr 0x00000100 -> mem_we 1 for 8 cycles writing 0x11..0x88 to 0x208..0x20F, then 8 read cycles, done in cycle 17, wb_cnt 1.
REQ-040 Back-pressure: req_valid held high across a transfer -> req_ready 0 and inputs ignored until after DONE; second accept on the first IDLE cycle.
REQ-041 Reset mid-WB: assert rst at idx 3 -> mem_we 0 from the next cycle, no done pulse, req_ready 1, counters 0.
REQ-042 Boundary and saturation: fill_addr 0xFFFFFFFF -> mem_addr 0xFFFFFFF8..0xFFFFFFFF; with CNT_W = 2, five requests -> req_cnt stays at 3.

Source files
------------

// File: rtl/mem_fill_sequencer_pkg.sv
// Shared definitions for the cache block fill/write-back sequencer.
// Holds the FSM state encoding and block geometry constants.
package mem_fill_sequencer_pkg;

    localparam int BLOCK_BYTES = 8;
    localparam int OFFSET_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Ports: clk, rst (sync, active-high), inc (count enable), count (value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fill_sequencer.sv
// Byte-serial cache block transfer: optional victim write-back, then fill.
// Ports: req_* handshake from the cache controller, wb_*/fill_* block info,
// mem_* byte-wide main memory port, done pulse, req_cnt/wb_cnt statistics.
module mem_fill_sequencer
    import mem_fill_sequencer_pkg::*;
#(
    parameter int BLOCK_BYTES = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_writeback,
    input  logic [31:0]      wb_addr,
    input  logic [63:0]      wb_line,
    input  logic [31:0]      fill_addr,
    output logic [63:0]      fill_line,
    output logic             done,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    input  logic [7:0]       mem_rdata,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(BLOCK_BYTES - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [OFFSET_W-1:0]      idx_q;
    logic [31:OFFSET_W]       wb_base_q;
    logic [31:OFFSET_W]       fill_base_q;
    logic [63:0]              wb_line_q;
    logic [63:0]              fill_line_q;
    logic                     accept;
    logic                     last;

    assign accept = req_valid && (state_q == IDLE);
    assign last   = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = req_writeback ? WB : FILL;
            WB:   if (last) state_d = FILL;
            FILL: if (last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes come straight from the state register so they cannot glitch.
    always_comb begin
        req_ready = (state_q == IDLE);
        done      = (state_q == DONE);
        mem_we    = (state_q == WB);
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            WB: begin
                mem_addr  = {wb_base_q, idx_q};
                mem_wdata = wb_line_q[{idx_q, 3'b000} +: 8];
            end
            FILL: mem_addr = {fill_base_q, idx_q};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q       <= '0;
                wb_base_q   <= wb_addr[31:OFFSET_W];
                fill_base_q <= fill_addr[31:OFFSET_W];
                wb_line_q   <= wb_line;
            end else if (state_q == WB || state_q == FILL) begin
                // Natural 3-bit wrap returns idx to 0 for the next phase.
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == FILL) begin
                fill_line_q[{idx_q, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

    assign fill_line = fill_line_q;

    sat_counter #(.WIDTH(CNT_W)) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (req_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && req_writeback),
        .count (wb_cnt)
    );

endmodule

// File: tb/tb_mem_fill_sequencer.sv
// Directed bench for mem_fill_sequencer with a byte-wide memory model.
// Table-driven transfers plus back-pressure and reset-abort sequences.
module tb_mem_fill_sequencer;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_writeback;
    logic [31:0]   wb_addr;
    logic [63:0]   wb_line;
    logic [31:0]   fill_addr;
    logic [63:0]   fill_line;
    logic          done;
    logic [31:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic [CW-1:0] req_cnt;
    logic [CW-1:0] wb_cnt;

    logic [7:0] mem [0:1023];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_fill_sequencer #(.BLOCK_BYTES(8), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_writeback (req_writeback),
        .wb_addr       (wb_addr),
        .wb_line       (wb_line),
        .fill_addr     (fill_addr),
        .fill_line     (fill_line),
        .done          (done),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .req_cnt       (req_cnt),
        .wb_cnt        (wb_cnt)
    );

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end

    typedef struct {
        logic        wb;
        logic [31:0] wb_addr;
        logic [63:0] wb_line;
        logic [31:0] fill_addr;
        logic [31:0] exp_wb_base;
        logic [31:0] exp_fill_base;
        logic [63:0] exp_line;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        int lat;
        int k;
        lat           = 0;
        req_writeback = v.wb;
        wb_addr       = v.wb_addr;
        wb_line       = v.wb_line;
        fill_addr     = v.fill_addr;
        req_valid     = 1'b1;
        check("ready_before", 64'(req_ready), 64'd1);
        tick;
        req_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (v.wb && c <= 8) begin
                check("wb_we", 64'(mem_we), 64'd1);
                check("wb_addr", 64'(mem_addr), 64'(v.exp_wb_base + 32'(c - 1)));
                check("wb_data", 64'(mem_wdata), 64'(v.wb_line[(c - 1) * 8 +: 8]));
            end else begin
                k = v.wb ? c - 9 : c - 1;
                check("fill_we", 64'(mem_we), 64'd0);
                check("fill_addr", 64'(mem_addr), 64'(v.exp_fill_base + 32'(k)));
            end
            tick;
        end
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("fill_line", fill_line, v.exp_line);
        tick;
    endtask

    initial begin
        int n_ready;
        int n_we;
        int n_done;
        int lat;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 8; i++) mem[256 + i] = 8'h10 + 8'(i);

        vecs[0] = '{1'b0, 32'h0, 64'h0, 32'h0000_0105,
                    32'h0, 32'h0000_0100, 64'h1716151413121110, 9};
        vecs[1] = '{1'b1, 32'h0000_0208, 64'h8877665544332211, 32'h0000_0100,
                    32'h0000_0208, 32'h0000_0100, 64'h1716151413121110, 17};
        vecs[2] = '{1'b0, 32'h0, 64'h0, 32'hFFFF_FFFF,
                    32'h0, 32'hFFFF_FFF8, 64'h5A5B58595E5F5C5D, 9};
        vecs[3] = '{1'b1, 32'h0000_030D, 64'hDEADBEEFCAFEF00D, 32'h0000_030A,
                    32'h0000_0308, 32'h0000_0308, 64'hDEADBEEFCAFEF00D, 17};
        vecs[4] = '{1'b0, 32'h0, 64'h0, 32'h0000_0047,
                    32'h0, 32'h0000_0040, 64'hE2E3E0E1E6E7E4E5, 9};

        // Reset with a simultaneous request: reset must win.
        rst           = 1'b1;
        req_valid     = 1'b1;
        req_writeback = 1'b1;
        wb_addr       = 32'h0000_0400;
        wb_line       = 64'h0;
        fill_addr     = 32'h0000_0040;
        tick;
        tick;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_line", fill_line, 64'd0);
        check("rst_req_cnt", 64'(req_cnt), 64'd0);
        check("rst_wb_cnt", 64'(wb_cnt), 64'd0);
        req_valid = 1'b0;
        rst       = 1'b0;
        tick;
        check("rst_prio_cnt", 64'(req_cnt), 64'd0);
        check("rst_prio_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        for (int i = 0; i < 8; i++)
            check("wb_mem", 64'(mem[10'h208 + 10'(i)]), 64'(8'h11 * 8'(i + 1)));
        check("req_cnt_sat", 64'(req_cnt), 64'd3);
        check("wb_cnt", 64'(wb_cnt), 64'd2);

        // Back-pressure: req_valid held, inputs change mid-transfer.
        req_writeback = 1'b0;
        fill_addr     = 32'h0000_0040;
        req_valid     = 1'b1;
        tick;
        fill_addr     = 32'h0000_0100;
        wb_addr       = 32'h0000_0500;
        wb_line       = 64'h0123456789ABCDEF;
        req_writeback = 1'b1;
        n_ready = 0;
        n_we    = 0;
        lat     = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (req_ready) n_ready++;
            if (mem_we) n_we++;
            if (c == 8) check("bp_addr_last", 64'(mem_addr), 64'h47);
            tick;
        end
        check("bp_latency", 64'(lat), 64'd9);
        check("bp_ready_busy", 64'(n_ready), 64'd0);
        check("bp_we_busy", 64'(n_we), 64'd0);
        check("bp_line", fill_line, 64'hE2E3E0E1E6E7E4E5);
        tick;
        check("bp_ready_idle", 64'(req_ready), 64'd1);
        tick;
        req_valid = 1'b0;
        check("bp_second_we", 64'(mem_we), 64'd1);
        check("bp_second_addr", 64'(mem_addr), 64'h500);
        check("bp_second_busy", 64'(req_ready), 64'd0);
        lat = 0;
        for (int c = 1; c <= 25; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            tick;
        end
        check("bp_second_lat", 64'(lat), 64'd17);
        tick;

        // Reset during write-back at idx 3.
        req_writeback = 1'b1;
        wb_addr       = 32'h0000_0600;
        fill_addr     = 32'h0000_0100;
        req_valid     = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        tick;
        check("mid_wb_we", 64'(mem_we), 64'd1);
        check("mid_wb_addr", 64'(mem_addr), 64'h603);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_line", fill_line, 64'd0);
        check("abort_req_cnt", 64'(req_cnt), 64'd0);
        check("abort_wb_cnt", 64'(wb_cnt), 64'd0);
        n_we   = 0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_we) n_we++;
            if (done) n_done++;
            tick;
        end
        check("abort_no_we", 64'(n_we), 64'd0);
        check("abort_no_done", 64'(n_done), 64'd0);

        // Reset during fill clears the partial line.
        req_writeback = 1'b0;
        fill_addr     = 32'h0000_0040;
        req_valid     = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_fill_line", fill_line, 64'd0);
        check("abort_fill_addr", 64'(mem_addr), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
